// File: rtl/em_skid_pipe.sv
// EX->MEM pipeline register with a one-entry skid buffer: full throughput with
// a registered in_ready, two-deep FIFO, bubble-gated write-enable flags.
module em_skid_pipe #(
  parameter int V = 128,
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         regw_E,
  input  logic         memw_E,
  input  logic         regmem_E,
  input  logic [M-1:0] regScr_E,
  input  logic [N-1:0] ALUrslt_E,
  input  logic [N-1:0] address_E,
  input  logic [V-1:0] regrsltV_E,
  input  logic [V-1:0] v_address_E,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         regw_M,
  output logic         memw_M,
  output logic         regmem_M,
  output logic [M-1:0] regScr_M,
  output logic [N-1:0] ALUrslt_M,
  output logic [N-1:0] address_M,
  output logic [V-1:0] regrsltV_M,
  output logic [V-1:0] v_address_M,
  output logic [1:0]   occupancy
);

  typedef struct packed {
    logic         regw;
    logic         memw;
    logic         regmem;
    logic [M-1:0] scr;
    logic [N-1:0] alu;
    logic [N-1:0] addr;
    logic [V-1:0] vres;
    logic [V-1:0] vaddr;
  } beat_t;

  beat_t      head;
  beat_t      skid;
  beat_t      in_beat;
  logic [1:0] occ;
  logic       accept;
  logic       retire;

  assign in_beat = '{regw: regw_E, memw: memw_E, regmem: regmem_E, scr: regScr_E,
                     alu: ALUrslt_E, addr: address_E, vres: regrsltV_E,
                     vaddr: v_address_E};

  // Handshake flags decode only the occupancy register, never out_ready/in_valid.
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      skid <= '0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      if (retire) begin
        if (occ == 2'd2) begin
          head <= skid;
        end else if (accept) begin
          head <= in_beat;
        end
      end else if (accept) begin
        if (occ == 2'd0) begin
          head <= in_beat;
        end else begin
          skid <= in_beat;
        end
      end
      occ <= occ + {1'b0, accept} - {1'b0, retire};
    end
  end

  // Write enables are masked so an empty stage never commits; data fields hold.
  assign regw_M      = head.regw & out_valid;
  assign memw_M      = head.memw & out_valid;
  assign regmem_M    = head.regmem & out_valid;
  assign regScr_M    = head.scr;
  assign ALUrslt_M   = head.alu;
  assign address_M   = head.addr;
  assign regrsltV_M  = head.vres;
  assign v_address_M = head.vaddr;
  assign occupancy   = occ;

endmodule

// File: tb/tb_em_skid_pipe.sv
// Scoreboard bench for em_skid_pipe: default-parameter instance (a) and a
// V=64/N=16/M=5 instance (b); stimulus pushes expected beats, monitors pop.
module tb_em_skid_pipe;

  typedef struct packed {
    logic         regw;
    logic         memw;
    logic         regmem;
    logic [4:0]   scr;
    logic [31:0]  alu;
    logic [31:0]  addr;
    logic [127:0] vres;
    logic [127:0] vaddr;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;
  beat_t in_a, in_b;
  logic in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [1:0] occ_a, occ_b;
  logic regw_M_a, memw_M_a, regmem_M_a, regw_M_b, memw_M_b, regmem_M_b;
  logic [3:0]   scr_M_a;
  logic [31:0]  alu_M_a, addr_M_a;
  logic [127:0] vres_M_a, vaddr_M_a;
  logic [4:0]   scr_M_b;
  logic [15:0]  alu_M_b, addr_M_b;
  logic [63:0]  vres_M_b, vaddr_M_b;

  beat_t qa[$];
  beat_t qb[$];
  int mocc_a, mocc_b;
  int compared = 0;
  int mismatched = 0;

  em_skid_pipe dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .regw_E(in_a.regw), .memw_E(in_a.memw), .regmem_E(in_a.regmem),
    .regScr_E(in_a.scr[3:0]), .ALUrslt_E(in_a.alu), .address_E(in_a.addr),
    .regrsltV_E(in_a.vres), .v_address_E(in_a.vaddr),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .regw_M(regw_M_a), .memw_M(memw_M_a), .regmem_M(regmem_M_a),
    .regScr_M(scr_M_a), .ALUrslt_M(alu_M_a), .address_M(addr_M_a),
    .regrsltV_M(vres_M_a), .v_address_M(vaddr_M_a), .occupancy(occ_a)
  );

  em_skid_pipe #(.V(64), .N(16), .M(5)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .regw_E(in_b.regw), .memw_E(in_b.memw), .regmem_E(in_b.regmem),
    .regScr_E(in_b.scr), .ALUrslt_E(in_b.alu[15:0]), .address_E(in_b.addr[15:0]),
    .regrsltV_E(in_b.vres[63:0]), .v_address_E(in_b.vaddr[63:0]),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .regw_M(regw_M_b), .memw_M(memw_M_b), .regmem_M(regmem_M_b),
    .regScr_M(scr_M_b), .ALUrslt_M(alu_M_b), .address_M(addr_M_b),
    .regrsltV_M(vres_M_b), .v_address_M(vaddr_M_b), .occupancy(occ_b)
  );

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_beat(input string nm, input beat_t got, input beat_t exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic rw, input logic mw, input logic rm,
                               input logic [3:0] scr, input logic [31:0] alu);
    beat_t b;
    b.regw   = rw;
    b.memw   = mw;
    b.regmem = rm;
    b.scr    = {1'b0, scr};
    b.alu    = alu;
    b.addr   = alu ^ 32'h5555_0000;
    b.vres   = {4{alu}};
    b.vaddr  = {4{~alu}};
    return b;
  endfunction

  function automatic beat_t mkb(input logic [7:0] i);
    beat_t b;
    logic [63:0] p;
    p        = 64'hA5A5_A5A5_A5A5_A5A5 + {56'd0, i};
    b.regw   = i[0];
    b.memw   = i[1];
    b.regmem = i[2];
    b.scr    = 5'h1F ^ i[4:0];
    b.alu    = {16'd0, 16'hA5A5 + {8'd0, i}};
    b.addr   = {16'd0, 16'h5A5A ^ {8'd0, i}};
    b.vres   = {64'd0, p};
    b.vaddr  = {64'd0, ~p};
    return b;
  endfunction

  function automatic beat_t out_a();
    beat_t b;
    b.regw = regw_M_a; b.memw = memw_M_a; b.regmem = regmem_M_a;
    b.scr = {1'b0, scr_M_a}; b.alu = alu_M_a; b.addr = addr_M_a;
    b.vres = vres_M_a; b.vaddr = vaddr_M_a;
    return b;
  endfunction

  function automatic beat_t out_b();
    beat_t b;
    b.regw = regw_M_b; b.memw = memw_M_b; b.regmem = regmem_M_b;
    b.scr = scr_M_b; b.alu = {16'd0, alu_M_b}; b.addr = {16'd0, addr_M_b};
    b.vres = {64'd0, vres_M_b}; b.vaddr = {64'd0, ~64'd0 & vaddr_M_b};
    return b;
  endfunction

  // Monitor: pop an expected beat whenever a head beat is consumed.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid_a && out_ready_a) begin
      if (qa.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_beat_a: got alu %0h expected no beat", alu_M_a);
      end else begin
        chk_beat("beat_a", out_a(), qa.pop_front());
      end
    end
    if (!rst && !flush && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_beat_b: got alu %0h expected no beat", alu_M_b);
      end else begin
        chk_beat("beat_b", out_b(), qb.pop_front());
      end
    end
    if (!out_valid_a) chk("bubble_flags_a", 128'({regw_M_a, memw_M_a, regmem_M_a}), 128'd0);
    if (!out_valid_b) chk("bubble_flags_b", 128'({regw_M_b, memw_M_b, regmem_M_b}), 128'd0);
  end

  task automatic cycle();
    bit acc_a, ret_a, acc_b, ret_b;
    chk("in_ready_a", 128'(in_ready_a), 128'(mocc_a < 2));
    chk("out_valid_a", 128'(out_valid_a), 128'(mocc_a > 0));
    chk("occupancy_a", 128'(occ_a), 128'(mocc_a));
    chk("in_ready_b", 128'(in_ready_b), 128'(mocc_b < 2));
    chk("occupancy_b", 128'(occ_b), 128'(mocc_b));
    acc_a = in_valid_a && (mocc_a < 2) && !flush;
    ret_a = (mocc_a > 0) && out_ready_a && !flush;
    acc_b = in_valid_b && (mocc_b < 2) && !flush;
    ret_b = (mocc_b > 0) && out_ready_b && !flush;
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (acc_a) qa.push_back(in_a);
      if (acc_b) qb.push_back(in_b);
    end
    @(posedge clk);
    #1;
    mocc_a = flush ? 0 : mocc_a + int'(acc_a) - int'(ret_a);
    mocc_b = flush ? 0 : mocc_b + int'(acc_b) - int'(ret_b);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; in_b = '0;
    mocc_a = 0; mocc_b = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_occupancy", 128'(occ_a), 128'd0);
    chk("rst_out_valid", 128'(out_valid_a), 128'd0);
    chk("rst_in_ready", 128'(in_ready_a), 128'd1);
    chk("rst_alu", 128'(alu_M_a), 128'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // streaming: ALU results 1..8, one per cycle
    out_ready_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_a = mk(i[0], i[1], i[2], i[3:0], 32'(i));
      in_valid_a = 1'b1;
      cycle();
      chk("stream_occupancy", 128'(occ_a), 128'd1);
    end
    in_valid_a = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // backpressure: A and B fill both slots, C waits
    out_ready_a = 1'b0;
    in_valid_a = 1'b1;
    in_a = mk(1'b1, 1'b0, 1'b0, 4'hA, 32'h0000_00AA); cycle();
    in_a = mk(1'b0, 1'b1, 1'b0, 4'hB, 32'h0000_00BB); cycle();
    in_a = mk(1'b0, 1'b0, 1'b1, 4'hC, 32'h0000_00CC);
    for (int i = 0; i < 3; i++) cycle();
    chk("bp_in_ready", 128'(in_ready_a), 128'd0);
    chk("bp_occupancy", 128'(occ_a), 128'd2);
    chk("bp_head_is_a", 128'(alu_M_a), 128'h0000_00AA);
    out_ready_a = 1'b1;
    cycle();
    cycle();
    in_valid_a = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // bubble gating after the last beat retires
    in_a = mk(1'b1, 1'b1, 1'b0, 4'h3, 32'hDEAD_BEEF);
    in_valid_a = 1'b1;
    cycle();
    in_valid_a = 1'b0;
    chk("bubble_regw_live", 128'(regw_M_a), 128'd1);
    cycle();
    chk("bubble_regw", 128'(regw_M_a), 128'd0);
    chk("bubble_memw", 128'(memw_M_a), 128'd0);
    chk("bubble_alu_hold", 128'(alu_M_a), 128'hDEAD_BEEF);

    // flush with both slots full and a beat on offer
    out_ready_a = 1'b0;
    in_valid_a = 1'b1;
    in_a = mk(1'b1, 1'b1, 1'b1, 4'h1, 32'h1111_0001); cycle();
    in_a = mk(1'b1, 1'b1, 1'b1, 4'h2, 32'h1111_0002); cycle();
    flush = 1'b1;
    in_a = mk(1'b1, 1'b1, 1'b1, 4'h7, 32'h0BAD_0BAD);
    cycle();
    flush = 1'b0;
    in_valid_a = 1'b0;
    chk("flush_occupancy", 128'(occ_a), 128'd0);
    chk("flush_out_valid", 128'(out_valid_a), 128'd0);
    chk("flush_flags", 128'({regw_M_a, memw_M_a, regmem_M_a}), 128'd0);
    chk("flush_in_ready", 128'(in_ready_a), 128'd1);
    out_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // asynchronous reset mid-cycle with two beats held
    out_ready_a = 1'b0;
    in_valid_a = 1'b1;
    in_a = mk(1'b1, 1'b0, 1'b0, 4'h4, 32'h2222_0004); cycle();
    in_a = mk(1'b0, 1'b1, 1'b0, 4'h5, 32'h2222_0005); cycle();
    in_valid_a = 1'b0;
    chk("pre_rst_occupancy", 128'(occ_a), 128'd2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_occupancy", 128'(occ_a), 128'd0);
    chk("midrst_out_valid", 128'(out_valid_a), 128'd0);
    chk("midrst_in_ready", 128'(in_ready_a), 128'd1);
    chk("midrst_alu", 128'(alu_M_a), 128'd0);
    qa.delete();
    mocc_a = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready_a = 1'b1;
    in_valid_a = 1'b1;
    in_a = mk(1'b0, 1'b0, 1'b1, 4'h6, 32'h1234_5678);
    cycle();
    in_valid_a = 1'b0;
    chk("post_rst_latency_valid", 128'(out_valid_a), 128'd1);
    chk("post_rst_latency_alu", 128'(alu_M_a), 128'h1234_5678);
    for (int i = 0; i < 2; i++) cycle();

    // parameter sweep instance: streaming with 0xA5 patterns
    out_ready_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_b = mkb(8'(i));
      in_valid_b = 1'b1;
      cycle();
    end
    in_valid_b = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    chk("queue_a_drained", 128'(qa.size()), 128'd0);
    chk("queue_b_drained", 128'(qb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
